// File: rtl/mac_block_if.sv
// Stream bundle for mac_block: one 64-bit upstream AXI-Stream plus LANES
// independent 8-bit downstream lanes. The slave side is the framing block.
interface mac_block_if #(
    parameter int unsigned LANES = 8
);
    logic                  s_axis_input_tvalid;
    logic                  s_axis_input_tready;
    logic [63:0]           s_axis_input_tdata;
    logic                  s_axis_input_tlast;
    logic [LANES-1:0]      m_axis_output_tvalid;
    logic [LANES-1:0]      m_axis_output_tready;
    logic [LANES-1:0][7:0] m_axis_output_tdata;
    logic [LANES-1:0]      m_axis_output_tlast;

    modport master (
        output s_axis_input_tvalid,
        output s_axis_input_tdata,
        output s_axis_input_tlast,
        output m_axis_output_tready,
        input  s_axis_input_tready,
        input  m_axis_output_tvalid,
        input  m_axis_output_tdata,
        input  m_axis_output_tlast
    );

    modport slave (
        input  s_axis_input_tvalid,
        input  s_axis_input_tdata,
        input  s_axis_input_tlast,
        input  m_axis_output_tready,
        output s_axis_input_tready,
        output m_axis_output_tvalid,
        output m_axis_output_tdata,
        output m_axis_output_tlast
    );
endinterface

// File: rtl/mac_block.sv
// mac_block: transmit-side MAC framing. Spreads each 64-bit upstream word
// round-robin over LANES byte lanes, cuts every lane into FRAME_BYTES frames
// and completes a short final frame with PAD_BYTE. Each lane has its own
// first-word-fall-through FIFO and drains independently.
module mac_block #(
    parameter int unsigned LANES       = 8,
    parameter int unsigned FRAME_BYTES = 239,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    mac_block_if.slave  axis,
    output logic        pad_active,
    output logic [15:0] frame_count
);
    localparam int unsigned W  = 8 / LANES;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(FRAME_BYTES + 1);

    typedef enum logic {
        STREAM,
        PAD
    } state_t;

    state_t state, stateNext;

    logic [CW-1:0]                      cnt, cntNext;
    logic [LANES-1:0][FIFO_DEPTH-1:0][8:0] mem;
    logic [LANES-1:0][PW-1:0]           wrPtr;
    logic [LANES-1:0][PW-1:0]           rdPtr;
    logic [LANES-1:0][LW-1:0]           level;
    logic [LANES-1:0]                   pop;
    logic [LW-1:0]                      pushCount;
    logic                               roomWord, roomPad;
    logic                               wordAccept, padWrite, frameDone;

    // Free-space summary across all lanes: room for a whole word / one pad byte.
    always_comb begin
        roomWord = 1'b1;
        roomPad  = 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (level[l] > LW'(FIFO_DEPTH - W)) roomWord = 1'b0;
            if (level[l] == LW'(FIFO_DEPTH))    roomPad  = 1'b0;
        end
    end

    // Next state, shared byte counter and push control.
    always_comb begin
        stateNext                = state;
        cntNext                  = cnt;
        axis.s_axis_input_tready = 1'b0;
        pad_active               = 1'b0;
        wordAccept               = 1'b0;
        padWrite                 = 1'b0;
        frameDone                = 1'b0;
        pushCount                = '0;
        unique case (state)
            STREAM: begin
                // Held low while reset is asserted so the reset value is 0.
                axis.s_axis_input_tready = roomWord && !reset;
                wordAccept = roomWord && !reset && axis.s_axis_input_tvalid;
                if (wordAccept) begin
                    pushCount = LW'(W);
                    if (cnt == CW'(FRAME_BYTES - W)) begin
                        cntNext   = '0;
                        frameDone = 1'b1;
                    end else begin
                        cntNext = cnt + CW'(W);
                        if (axis.s_axis_input_tlast) stateNext = PAD;
                    end
                end
            end
            PAD: begin
                pad_active = 1'b1;
                padWrite   = roomPad;
                if (roomPad) begin
                    pushCount = LW'(1);
                    if (cnt == CW'(FRAME_BYTES - 1)) begin
                        cntNext   = '0;
                        frameDone = 1'b1;
                        stateNext = STREAM;
                    end else begin
                        cntNext = cnt + CW'(1);
                    end
                end
            end
            default: stateNext = STREAM;
        endcase
    end

    // State, byte counter and completed-frame counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STREAM;
            cnt         <= '0;
            frame_count <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (frameDone) frame_count <= frame_count + 16'd1;
        end
    end

    // Lane FIFO storage: W bytes per lane per word, or one pad byte per lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (wordAccept) begin
                    for (int unsigned j = 0; j < W; j++) begin
                        mem[l][wrPtr[l] + PW'(j)] <=
                            {(32'(cnt) + j) == (FRAME_BYTES - 1),
                             axis.s_axis_input_tdata[8*(l + j*LANES) +: 8]};
                    end
                end else if (padWrite) begin
                    mem[l][wrPtr[l]] <= {cnt == CW'(FRAME_BYTES - 1), PAD_BYTE};
                end
                wrPtr[l] <= wrPtr[l] + pushCount[PW-1:0];
                if (pop[l]) rdPtr[l] <= rdPtr[l] + PW'(1);
                level[l] <= level[l] + pushCount - LW'(pop[l]);
            end
        end
    end

    // Fall-through lane outputs straight from each FIFO head.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            axis.m_axis_output_tvalid[l] = (level[l] != '0);
            {axis.m_axis_output_tlast[l], axis.m_axis_output_tdata[l]} = mem[l][rdPtr[l]];
            pop[l] = (level[l] != '0) && axis.m_axis_output_tready[l];
        end
    end
endmodule

// File: tb/tb_mac_block.sv
// Bench for mac_block: an 8-lane instance (239-byte frames, zero pad) and a
// 4-lane instance (10-byte frames, 0xA5 pad), each checked against a
// queue-based frame model fed from observed upstream handshakes.
module tb_mac_block;
    localparam int unsigned L8   = 8;
    localparam int unsigned FB8  = 239;
    localparam int unsigned D8   = 16;
    localparam int unsigned L4   = 4;
    localparam int unsigned FB4  = 10;
    localparam int unsigned D4   = 16;
    localparam logic [7:0]  PAD8 = 8'h00;
    localparam logic [7:0]  PAD4 = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_block_if #(.LANES(L8)) bus8 ();
    mac_block_if #(.LANES(L4)) bus4 ();
    logic        pad8, pad4;
    logic [15:0] fc8, fc4;

    mac_block #(.LANES(L8), .FRAME_BYTES(FB8), .FIFO_DEPTH(D8), .PAD_BYTE(PAD8)) dut8 (
        .clk(clk), .reset(reset), .axis(bus8.slave), .pad_active(pad8), .frame_count(fc8)
    );
    mac_block #(.LANES(L4), .FRAME_BYTES(FB4), .FIFO_DEPTH(D4), .PAD_BYTE(PAD4)) dut4 (
        .clk(clk), .reset(reset), .axis(bus4.slave), .pad_active(pad4), .frame_count(fc4)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [8:0]  expQ [2][8][$];
    int unsigned pos [2];
    int unsigned frames [2];
    int unsigned spurious [2];
    int unsigned padCycles8, padReadyBad, acceptCount;
    logic        acc8, acc4, rndRdy;
    logic [7:0]  stall8;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic advance(input int unsigned inst, input int unsigned fb);
        pos[inst]++;
        if (pos[inst] == fb) begin
            pos[inst] = 0;
            frames[inst]++;
        end
    endtask

    // Byte k goes to lane k mod lanes; a frame ends every fb bytes per lane,
    // and a packet end off a frame boundary is followed by pad bytes.
    task automatic modelWord(input int unsigned inst, input int unsigned lanes,
                             input int unsigned fb, input logic [7:0] padB,
                             input logic [63:0] d, input logic lst);
        for (int unsigned j = 0; j < 8 / lanes; j++) begin
            for (int unsigned l = 0; l < lanes; l++)
                expQ[inst][l].push_back({pos[inst] == fb - 1, d[8*(l + j*lanes) +: 8]});
            advance(inst, fb);
        end
        if (lst) begin
            while (pos[inst] != 0) begin
                for (int unsigned l = 0; l < lanes; l++)
                    expQ[inst][l].push_back({pos[inst] == fb - 1, padB});
                advance(inst, fb);
            end
        end
    endtask

    task automatic popCheck(input int unsigned inst, input int unsigned l, input logic [8:0] obs);
        logic [8:0] e;
        if (expQ[inst][l].size() == 0) begin
            spurious[inst]++;
        end else begin
            e = expQ[inst][l].pop_front();
            check($sformatf("byte inst%0d lane%0d", inst, l), 64'(obs), 64'(e));
        end
    endtask

    function automatic logic isIdle();
        logic idle;
        idle = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int l = 0; l < 8; l++)
                if (expQ[i][l].size() != 0) idle = 1'b0;
        if (bus8.m_axis_output_tvalid != '0 || bus4.m_axis_output_tvalid != '0 || pad8 || pad4)
            idle = 1'b0;
        return idle;
    endfunction

    // One clock: set readies, sample handshakes at the falling edge, advance.
    task automatic step();
        for (int l = 0; l < L8; l++)
            bus8.m_axis_output_tready[l] = !stall8[l] && (!rndRdy || ($urandom_range(3) != 0));
        for (int l = 0; l < L4; l++)
            bus4.m_axis_output_tready[l] = !rndRdy || ($urandom_range(3) != 0);
        @(negedge clk);
        for (int unsigned l = 0; l < L8; l++)
            if (bus8.m_axis_output_tvalid[l] && bus8.m_axis_output_tready[l])
                popCheck(0, l, {bus8.m_axis_output_tlast[l], bus8.m_axis_output_tdata[l]});
        for (int unsigned l = 0; l < L4; l++)
            if (bus4.m_axis_output_tvalid[l] && bus4.m_axis_output_tready[l])
                popCheck(1, l, {bus4.m_axis_output_tlast[l], bus4.m_axis_output_tdata[l]});
        acc8 = bus8.s_axis_input_tvalid && bus8.s_axis_input_tready;
        acc4 = bus4.s_axis_input_tvalid && bus4.s_axis_input_tready;
        if (acc8) modelWord(0, L8, FB8, PAD8, bus8.s_axis_input_tdata, bus8.s_axis_input_tlast);
        if (acc4) modelWord(1, L4, FB4, PAD4, bus4.s_axis_input_tdata, bus4.s_axis_input_tlast);
        if (pad8) begin
            padCycles8++;
            if (bus8.s_axis_input_tready) padReadyBad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord8(input logic [63:0] d, input logic lst);
        int unsigned n;
        n = 0;
        bus8.s_axis_input_tvalid = 1'b1;
        bus8.s_axis_input_tdata  = d;
        bus8.s_axis_input_tlast  = lst;
        do begin
            step();
            n++;
        end while (!acc8 && n < 3000);
        bus8.s_axis_input_tvalid = 1'b0;
        check("send8 accepted", acc8, 1);
    endtask

    task automatic sendWord4(input logic [63:0] d, input logic lst);
        int unsigned n;
        n = 0;
        bus4.s_axis_input_tvalid = 1'b1;
        bus4.s_axis_input_tdata  = d;
        bus4.s_axis_input_tlast  = lst;
        do begin
            step();
            n++;
        end while (!acc4 && n < 3000);
        bus4.s_axis_input_tvalid = 1'b0;
        check("send4 accepted", acc4, 1);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (n < budget && !isIdle()) begin
            step();
            n++;
        end
        check("drain reached idle", isIdle(), 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; frames[i] = 0; spurious[i] = 0;
        end
        padCycles8 = 0; padReadyBad = 0; acceptCount = 0;
        acc8 = 1'b0; acc4 = 1'b0; rndRdy = 1'b0; stall8 = '0;
        bus8.s_axis_input_tvalid = 1'b0; bus8.s_axis_input_tdata = '0;
        bus8.s_axis_input_tlast  = 1'b0; bus8.m_axis_output_tready = '1;
        bus4.s_axis_input_tvalid = 1'b0; bus4.s_axis_input_tdata = '0;
        bus4.s_axis_input_tlast  = 1'b0; bus4.m_axis_output_tready = '1;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst tready8", bus8.s_axis_input_tready, 0);
        check("rst tvalid8", bus8.m_axis_output_tvalid, 0);
        check("rst tlast8", bus8.m_axis_output_tlast, 0);
        check("rst tdata8", bus8.m_axis_output_tdata, 0);
        check("rst pad8", pad8, 0);
        check("rst fc8", fc8, 0);
        check("rst tvalid4", bus4.m_axis_output_tvalid, 0);
        reset = 1'b0;
        #1;
        check("post-rst tready8", bus8.s_axis_input_tready, 1);
        check("post-rst tready4", bus4.s_axis_input_tready, 1);

        // First word lands on lanes one cycle later
        bus8.s_axis_input_tvalid = 1'b1;
        bus8.s_axis_input_tdata  = 64'h0706050403020100;
        bus8.s_axis_input_tlast  = 1'b0;
        step();
        bus8.s_axis_input_tvalid = 1'b0;
        check("T1 accept", acc8, 1);
        check("T1 tvalid", bus8.m_axis_output_tvalid, 8'hFF);
        check("T1 tdata", bus8.m_axis_output_tdata, 64'h0706050403020100);
        check("T1 tlast", bus8.m_axis_output_tlast, 0);

        // Full frame, then a second frame whose packet ends on the boundary
        rndRdy = 1'b1;
        repeat (FB8 - 1) sendWord8(rnd64(), 1'b0);
        check("T2 fc after one frame", fc8, 1);
        sendWord8(rnd64(), 1'b0);
        padCycles8 = 0;
        repeat (FB8 - 2) sendWord8(rnd64(), 1'b0);
        sendWord8(rnd64(), 1'b1);
        drain(3000);
        check("T2 no pad on boundary tlast", padCycles8, 0);
        check("T2 fc after two frames", fc8, 2);

        // Short packet padded out
        rndRdy = 1'b0;
        padCycles8 = 0;
        padReadyBad = 0;
        repeat (9) sendWord8(rnd64(), 1'b0);
        sendWord8(rnd64(), 1'b1);
        drain(1000);
        check("T3 pad cycles", padCycles8, FB8 - 10);
        check("T3 tready during pad", padReadyBad, 0);
        check("T3 fc", fc8, 3);

        // Stalled lane 3 backpressures the input
        stall8 = 8'h08;
        acceptCount = 0;
        bus8.s_axis_input_tvalid = 1'b1;
        bus8.s_axis_input_tdata  = rnd64();
        bus8.s_axis_input_tlast  = 1'b0;
        repeat (40) begin
            step();
            if (acc8) begin
                acceptCount++;
                bus8.s_axis_input_tdata = rnd64();
            end
        end
        bus8.s_axis_input_tvalid = 1'b0;
        check("T4 words accepted while stalled", acceptCount, D8);
        check("T4 tready low", bus8.s_axis_input_tready, 0);
        check("T4 only lane3 holds data", bus8.m_axis_output_tvalid, 8'h08);
        stall8 = '0;
        sendWord8(rnd64(), 1'b1);
        drain(1000);
        check("T4 fc", fc8, 4);

        // Reset in the middle of padding
        repeat (4) sendWord8(rnd64(), 1'b0);
        sendWord8(rnd64(), 1'b1);
        repeat (3) step();
        check("T5 pad before reset", pad8, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("T5 tvalid in reset", bus8.m_axis_output_tvalid, 0);
        check("T5 pad in reset", pad8, 0);
        check("T5 fc in reset", fc8, 0);
        check("T5 tready in reset", bus8.s_axis_input_tready, 0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < 8; l++) expQ[i][l].delete();
            pos[i] = 0;
            frames[i] = 0;
        end
        #1;
        check("T5 tready after reset", bus8.s_axis_input_tready, 1);
        repeat (20) step();
        check("T5 nothing emitted after reset", bus8.m_axis_output_tvalid, 0);
        check("T5 pad stays low", pad8, 0);

        // Random packets with random downstream readiness
        rndRdy = 1'b1;
        repeat (300) sendWord8(rnd64(), $urandom_range(7) == 0);
        drain(5000);
        check("T6 fc8 vs model", fc8, 16'(frames[0]));

        // Four-lane instance: two bytes per lane per word
        rndRdy = 1'b0;
        bus4.s_axis_input_tvalid = 1'b1;
        bus4.s_axis_input_tdata  = 64'h0706050403020100;
        bus4.s_axis_input_tlast  = 1'b0;
        step();
        bus4.s_axis_input_tvalid = 1'b0;
        check("T7 accept", acc4, 1);
        check("T7 tvalid first", bus4.m_axis_output_tvalid, 4'hF);
        check("T7 tdata first", bus4.m_axis_output_tdata, 32'h03020100);
        check("T7 tlast first", bus4.m_axis_output_tlast, 0);
        step();
        check("T7 tvalid second", bus4.m_axis_output_tvalid, 4'hF);
        check("T7 tdata second", bus4.m_axis_output_tdata, 32'h07060504);
        sendWord4(rnd64(), 1'b1);
        drain(200);
        check("T7 fc4", fc4, 1);

        rndRdy = 1'b1;
        repeat (200) sendWord4(rnd64(), $urandom_range(3) == 0);
        drain(2000);
        check("T8 fc4 vs model", fc4, 16'(frames[1]));

        check("no spurious bytes lanes8", spurious[0], 0);
        check("no spurious bytes lanes4", spurious[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
